// File: rtl/axi_arb_pkg.sv
// Shared types and widths for the AXI-lite SRAM arbiter.
//   arb_state_t : arbiter FSM states (idle, read routed, write routed)
//   MST_IFU/LSU : grant encodings for the two masters
//   AXI_*_BUS   : default AXI-lite bus widths
package axi_arb_pkg;

  localparam int AXI_ADDR_BUS = 32;
  localparam int AXI_DATA_BUS = 32;
  localparam int AXI_RESP_BUS = 2;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_RD   = 2'd1,
    ARB_WR   = 2'd2
  } arb_state_t;

  localparam logic MST_IFU = 1'b0;
  localparam logic MST_LSU = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker, purely combinational.
//   req[1:0] : request lines (bit 0 = requester 0)
//   last     : requester served most recently
//   gnt      : winning requester index
//   any      : at least one request present
// On a tie the requester that was not served last wins; with a single
// request that requester wins regardless of last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt,
  output logic       any
);

  always_comb begin
    any = |req;
    if (req == 2'b11) begin
      gnt = ~last;
    end else begin
      gnt = req[1];
    end
  end

endmodule

// File: rtl/axi_lite_mem_arbiter.sv
// Shares one AXI-lite SRAM slave between the IFU (M0, read-only) and the
// LSU (M1, read + write). One transaction is in flight at a time; reads are
// granted round-robin and an LSU write beats any pending read.
//   clk, rst                : clock, asynchronous active-high reset
//   m0_ar*, m0_r*           : IFU read address / read data channels
//   m1_ar*, m1_r*           : LSU read address / read data channels
//   m1_aw*, m1_w*, m1_b*    : LSU write address / data / response channels
//   s_*                     : the same five channels towards the SRAM slave
// All routing is combinational from the registered state, so the data path
// has zero latency and every output is zero while idle (and hence in reset).
module axi_lite_mem_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_BUS,
  parameter int DATA_W = AXI_DATA_BUS
) (
  input  logic                    clk,
  input  logic                    rst,
  // IFU master
  input  logic [ADDR_W-1:0]       m0_araddr,
  input  logic                    m0_arvalid,
  output logic                    m0_arready,
  output logic [DATA_W-1:0]       m0_rdata,
  output logic [AXI_RESP_BUS-1:0] m0_rresp,
  output logic                    m0_rvalid,
  input  logic                    m0_rready,
  // LSU master
  input  logic [ADDR_W-1:0]       m1_araddr,
  input  logic                    m1_arvalid,
  output logic                    m1_arready,
  output logic [DATA_W-1:0]       m1_rdata,
  output logic [AXI_RESP_BUS-1:0] m1_rresp,
  output logic                    m1_rvalid,
  input  logic                    m1_rready,
  input  logic [ADDR_W-1:0]       m1_awaddr,
  input  logic                    m1_awvalid,
  output logic                    m1_awready,
  input  logic [DATA_W-1:0]       m1_wdata,
  input  logic [DATA_W/8-1:0]     m1_wstrb,
  input  logic                    m1_wvalid,
  output logic                    m1_wready,
  output logic [AXI_RESP_BUS-1:0] m1_bresp,
  output logic                    m1_bvalid,
  input  logic                    m1_bready,
  // SRAM slave
  output logic [ADDR_W-1:0]       s_araddr,
  output logic                    s_arvalid,
  input  logic                    s_arready,
  input  logic [DATA_W-1:0]       s_rdata,
  input  logic [AXI_RESP_BUS-1:0] s_rresp,
  input  logic                    s_rvalid,
  output logic                    s_rready,
  output logic [ADDR_W-1:0]       s_awaddr,
  output logic                    s_awvalid,
  input  logic                    s_awready,
  output logic [DATA_W-1:0]       s_wdata,
  output logic [DATA_W/8-1:0]     s_wstrb,
  output logic                    s_wvalid,
  input  logic                    s_wready,
  input  logic [AXI_RESP_BUS-1:0] s_bresp,
  input  logic                    s_bvalid,
  output logic                    s_bready
);

  arb_state_t state_q, state_d;
  logic       gnt_q, gnt_d;
  logic       last_q, last_d;
  logic       ar_done_q, ar_done_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;

  logic [1:0] rd_req;
  logic       rr_gnt;
  logic       rr_any;

  logic       ar_hs, r_hs, aw_hs, w_hs, b_hs;

  // Read arbitration looks at the live valids; nothing is latched, so a
  // master simply keeps its valid high until the grant reaches it.
  assign rd_req = {m1_arvalid, m0_arvalid};

  rr_arb2 u_rr_arb2 (
    .req  (rd_req),
    .last (last_q),
    .gnt  (rr_gnt),
    .any  (rr_any)
  );

  // Slave-side handshakes; all are zero while idle because the routed
  // valids/readies are zero there.
  assign ar_hs = s_arvalid & s_arready;
  assign r_hs  = s_rvalid  & s_rready;
  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid  & s_wready;
  assign b_hs  = s_bvalid  & s_bready;

  // ---- state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      gnt_q     <= MST_IFU;
      last_q    <= MST_LSU;
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      ar_done_q <= ar_done_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    ar_done_d = ar_done_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    unique case (state_q)
      ARB_IDLE: begin
        // Grant takes effect next cycle, which also guarantees one idle
        // cycle between the end of one transaction and the next grant.
        if (m1_awvalid) begin
          state_d = ARB_WR;
          gnt_d   = MST_LSU;
        end else if (rr_any) begin
          state_d = ARB_RD;
          gnt_d   = rr_gnt;
        end
      end

      ARB_RD: begin
        if (ar_hs) begin
          ar_done_d = 1'b1;
        end
        if (r_hs) begin
          state_d   = ARB_IDLE;
          last_d    = gnt_q;
          ar_done_d = 1'b0;
        end
      end

      ARB_WR: begin
        if (aw_hs) begin
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          w_done_d = 1'b1;
        end
        if (b_hs) begin
          state_d   = ARB_IDLE;
          last_d    = MST_LSU;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end

      default: begin
        state_d   = ARB_IDLE;
        ar_done_d = 1'b0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
      end
    endcase
  end

  // ---- channel routing ----
  always_comb begin
    m0_arready = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = '0;
    m0_rvalid  = 1'b0;
    m1_arready = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = '0;
    m1_rvalid  = 1'b0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bresp   = '0;
    m1_bvalid  = 1'b0;
    s_araddr   = '0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    s_awaddr   = '0;
    s_awvalid  = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;

    if (state_q == ARB_RD) begin
      // Once AR has been accepted the address channel is closed so a
      // master that keeps arvalid high cannot issue a second request.
      if (gnt_q == MST_IFU) begin
        s_araddr   = m0_araddr;
        s_arvalid  = m0_arvalid & ~ar_done_q;
        m0_arready = s_arready  & ~ar_done_q;
        s_rready   = m0_rready;
        m0_rdata   = s_rdata;
        m0_rresp   = s_rresp;
        m0_rvalid  = s_rvalid;
      end else begin
        s_araddr   = m1_araddr;
        s_arvalid  = m1_arvalid & ~ar_done_q;
        m1_arready = s_arready  & ~ar_done_q;
        s_rready   = m1_rready;
        m1_rdata   = s_rdata;
        m1_rresp   = s_rresp;
        m1_rvalid  = s_rvalid;
      end
    end else if (state_q == ARB_WR) begin
      // AW and W close independently; either may finish first.
      s_awaddr   = m1_awaddr;
      s_awvalid  = m1_awvalid & ~aw_done_q;
      m1_awready = s_awready  & ~aw_done_q;
      s_wdata    = m1_wdata;
      s_wstrb    = m1_wstrb;
      s_wvalid   = m1_wvalid  & ~w_done_q;
      m1_wready  = s_wready   & ~w_done_q;
      s_bready   = m1_bready;
      m1_bresp   = s_bresp;
      m1_bvalid  = s_bvalid;
    end
  end

endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
module tb_axi_lite_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] m0_araddr;
  logic              m0_arvalid;
  logic              m0_arready;
  logic [DATA_W-1:0] m0_rdata;
  logic [1:0]        m0_rresp;
  logic              m0_rvalid;
  logic              m0_rready;
  logic [ADDR_W-1:0] m1_araddr;
  logic              m1_arvalid;
  logic              m1_arready;
  logic [DATA_W-1:0] m1_rdata;
  logic [1:0]        m1_rresp;
  logic              m1_rvalid;
  logic              m1_rready;
  logic [ADDR_W-1:0] m1_awaddr;
  logic              m1_awvalid;
  logic              m1_awready;
  logic [DATA_W-1:0] m1_wdata;
  logic [3:0]        m1_wstrb;
  logic              m1_wvalid;
  logic              m1_wready;
  logic [1:0]        m1_bresp;
  logic              m1_bvalid;
  logic              m1_bready;
  logic [ADDR_W-1:0] s_araddr;
  logic              s_arvalid;
  logic              s_arready;
  logic [DATA_W-1:0] s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rvalid;
  logic              s_rready;
  logic [ADDR_W-1:0] s_awaddr;
  logic              s_awvalid;
  logic              s_awready;
  logic [DATA_W-1:0] s_wdata;
  logic [3:0]        s_wstrb;
  logic              s_wvalid;
  logic              s_wready;
  logic [1:0]        s_bresp;
  logic              s_bvalid;
  logic              s_bready;

  axi_lite_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  // OR of every DUT output: must be 0 whenever the arbiter is idle or in reset
  logic any_out;
  assign any_out = |{m0_arready, m0_rdata, m0_rresp, m0_rvalid,
                     m1_arready, m1_rdata, m1_rresp, m1_rvalid,
                     m1_awready, m1_wready, m1_bresp, m1_bvalid,
                     s_araddr, s_arvalid, s_rready, s_awaddr, s_awvalid,
                     s_wdata, s_wstrb, s_wvalid, s_bready};

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: master served most recently (reset value = LSU)
  bit model_last = 1'b1;

  // Per-round transaction description
  logic [ADDR_W-1:0] r_a0, r_a1, r_aw;
  logic [DATA_W-1:0] r_d0, r_d1, r_wdata;
  logic [3:0]        r_wstrb;
  int                r_awd, r_wd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_araddr = '0; m0_arvalid = 1'b0;
    m1_araddr = '0; m1_arvalid = 1'b0;
    m1_awaddr = '0; m1_awvalid = 1'b0;
    m1_wdata = '0; m1_wstrb = '0; m1_wvalid = 1'b0;
    s_arready = 1'b0; s_rdata = '0; s_rresp = '0; s_rvalid = 1'b0;
    s_awready = 1'b0; s_wready = 1'b0; s_bresp = '0; s_bvalid = 1'b0;
    m0_rready = 1'b1; m1_rready = 1'b1; m1_bready = 1'b1;
  endtask

  // Acts as the SRAM slave for one read that must already be granted to
  // master k on the cycle after this task's first clock edge.
  task automatic serve_read(input bit k, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int ard, rdl;
    logic [1:0] rr;
    logic gv, ov;
    logic [DATA_W-1:0] gd, od;
    logic [1:0] gr;
    ard = $urandom_range(0, 2);
    rdl = $urandom_range(0, 3);
    rr  = 2'($urandom_range(0, 3));
    clk_step(); #1;
    n_chk++;
    if (s_arvalid !== 1'b1 || s_awvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_grant_latency: s_arvalid=%b s_awvalid=%b, required 1/0", s_arvalid, s_awvalid);
    end
    n_chk++;
    if (s_araddr !== a) begin
      n_fail++;
      $display("FAIL rd_addr: s_araddr=%h, required %h (master %0d)", s_araddr, a, k);
    end
    for (int i = 0; i < ard; i++) begin
      clk_step(); #1;
    end
    s_arready = 1'b1; #1;
    n_chk++;
    if ({m1_arready, m0_arready} !== (k ? 2'b10 : 2'b01)) begin
      n_fail++;
      $display("FAIL rd_arready_route: {m1,m0}_arready=%b, required %b", {m1_arready, m0_arready}, (k ? 2'b10 : 2'b01));
    end
    clk_step(); s_arready = 1'b0; #1;
    // granted master keeps arvalid high until the R handshake
    n_chk++;
    if (s_arvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL ar_once: s_arvalid=%b after AR handshake, required 0", s_arvalid);
    end
    for (int i = 0; i < rdl; i++) begin
      clk_step(); #1;
      n_chk++;
      if (s_arvalid !== 1'b0 || m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL rd_wait: s_arvalid=%b m0_rvalid=%b m1_rvalid=%b, required 0/0/0", s_arvalid, m0_rvalid, m1_rvalid);
      end
    end
    s_rvalid = 1'b1; s_rdata = d; s_rresp = rr; #1;
    gv = k ? m1_rvalid : m0_rvalid;
    gd = k ? m1_rdata  : m0_rdata;
    gr = k ? m1_rresp  : m0_rresp;
    ov = k ? m0_rvalid : m1_rvalid;
    od = k ? m0_rdata  : m1_rdata;
    n_chk++;
    if (gv !== 1'b1 || gd !== d || gr !== rr) begin
      n_fail++;
      $display("FAIL rd_data: master %0d rvalid=%b rdata=%h rresp=%b, required 1 %h %b", k, gv, gd, gr, d, rr);
    end
    n_chk++;
    if (ov !== 1'b0 || od !== '0) begin
      n_fail++;
      $display("FAIL rd_other_quiet: other master rvalid=%b rdata=%h, required 0 0", ov, od);
    end
    n_chk++;
    if (s_rready !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_rready: s_rready=%b, required 1", s_rready);
    end
    clk_step();
    s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
    if (k) m1_arvalid = 1'b0; else m0_arvalid = 1'b0;
    #1;
    n_chk++;
    if (s_arvalid !== 1'b0 || s_awvalid !== 1'b0 || s_rready !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_idle_gap: s_arvalid=%b s_awvalid=%b s_rready=%b, required 0/0/0", s_arvalid, s_awvalid, s_rready);
    end
  endtask

  // Acts as the SRAM slave for one LSU write; slave readies rise at
  // r_awd / r_wd and stay high, so a repeated forward would be counted.
  task automatic serve_write();
    int bd, last_c, awn, wn;
    logic [1:0] rb;
    bd  = $urandom_range(0, 3);
    rb  = 2'($urandom_range(0, 3));
    awn = 0;
    wn  = 0;
    clk_step(); #1;
    n_chk++;
    if (s_awvalid !== 1'b1 || s_wvalid !== 1'b1 || s_arvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_grant: s_awvalid=%b s_wvalid=%b s_arvalid=%b, required 1/1/0", s_awvalid, s_wvalid, s_arvalid);
    end
    n_chk++;
    if (s_awaddr !== r_aw || s_wdata !== r_wdata || s_wstrb !== r_wstrb) begin
      n_fail++;
      $display("FAIL wr_payload: %h/%h/%h, required %h/%h/%h", s_awaddr, s_wdata, s_wstrb, r_aw, r_wdata, r_wstrb);
    end
    last_c = ((r_awd > r_wd) ? r_awd : r_wd) + 2;
    for (int c = 0; c <= last_c; c++) begin
      s_awready = (c >= r_awd);
      s_wready  = (c >= r_wd);
      #1;
      if (s_awvalid && s_awready) awn++;
      if (s_wvalid && s_wready) wn++;
      n_chk++;
      if (m0_arready !== 1'b0 || m1_arready !== 1'b0 || m1_bvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL wr_blocking: m0_arready=%b m1_arready=%b m1_bvalid=%b, required 0/0/0", m0_arready, m1_arready, m1_bvalid);
      end
      n_chk++;
      if (m1_awready !== (s_awvalid & s_awready) || m1_wready !== (s_wvalid & s_wready)) begin
        n_fail++;
        $display("FAIL wr_ready_route: m1_awready=%b m1_wready=%b, required %b %b", m1_awready, m1_wready, s_awvalid & s_awready, s_wvalid & s_wready);
      end
      clk_step();
    end
    s_awready = 1'b0;
    s_wready  = 1'b0;
    n_chk++;
    if (awn != 1 || wn != 1) begin
      n_fail++;
      $display("FAIL wr_forward_once: aw=%0d w=%0d handshakes, required 1 1", awn, wn);
    end
    for (int i = 0; i < bd; i++) begin
      #1;
      n_chk++;
      if (m1_bvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL wr_b_early: m1_bvalid=%b, required 0", m1_bvalid);
      end
      clk_step();
    end
    s_bvalid = 1'b1; s_bresp = rb; #1;
    n_chk++;
    if (m1_bvalid !== 1'b1 || m1_bresp !== rb || s_bready !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_b: m1_bvalid=%b m1_bresp=%b s_bready=%b, required 1 %b 1", m1_bvalid, m1_bresp, s_bready, rb);
    end
    clk_step();
    s_bvalid = 1'b0; s_bresp = '0;
    m1_awvalid = 1'b0; m1_wvalid = 1'b0;
    #1;
    n_chk++;
    if (s_awvalid !== 1'b0 || s_wvalid !== 1'b0 || s_bready !== 1'b0 || s_arvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_idle_gap: s_awvalid=%b s_wvalid=%b s_bready=%b s_arvalid=%b, required 0", s_awvalid, s_wvalid, s_bready, s_arvalid);
    end
  endtask

  // Raises the requests in mask (bit0 M0 read, bit1 M1 read, bit2 M1 write)
  // together from idle and serves them in the order the rules dictate:
  // write first, then reads, ties going to the master not served last.
  task automatic run_round(input logic [2:0] mask);
    bit p0, p1, pw, k;
    p0 = mask[0]; p1 = mask[1]; pw = mask[2];
    m0_araddr = r_a0; m0_arvalid = p0;
    m1_araddr = r_a1; m1_arvalid = p1;
    m1_awaddr = r_aw; m1_awvalid = pw;
    m1_wdata = r_wdata; m1_wstrb = r_wstrb; m1_wvalid = pw;
    #1;
    n_chk++;
    if (s_arvalid !== 1'b0 || s_awvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cycle_grant: s_arvalid=%b s_awvalid=%b, required 0/0", s_arvalid, s_awvalid);
    end
    while (p0 || p1 || pw) begin
      if (pw) begin
        serve_write();
        pw = 1'b0;
        model_last = 1'b1;
      end else begin
        k = (p0 && p1) ? !model_last : p1;
        serve_read(k, k ? r_a1 : r_a0, k ? r_d1 : r_d0);
        if (k) p1 = 1'b0; else p0 = 1'b0;
        model_last = k;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m0_arvalid = 1'b1; m1_arvalid = 1'b1; m1_awvalid = 1'b1; m1_wvalid = 1'b1;
    s_rvalid = 1'b1; s_bvalid = 1'b1; s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
    s_rdata = 32'hFFFF_FFFF; m1_wdata = 32'h1234_5678;
    #1;
    n_chk++;
    if (any_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs_initial: any output=%b, required 0", any_out);
    end
    clk_step(); clk_step(); #1;
    n_chk++;
    if (any_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs_clocked: any output=%b, required 0", any_out);
    end
    clear_inputs();
    clk_step();
    rst = 1'b0;
    model_last = 1'b1;
    #1;
    n_chk++;
    if (any_out !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_outputs: any output=%b, required 0", any_out);
    end
  endtask

  task automatic test_m0_alone();
    r_a0 = 32'h8000_0000; r_d0 = 32'h0000_0413;
    run_round(3'b001);
  endtask

  task automatic test_rr_pair();
    r_a0 = 32'h8000_0040; r_a1 = 32'h8000_0100;
    r_d0 = 32'h1111_0000; r_d1 = 32'h2222_0000;
    for (int i = 0; i < 3; i++) begin
      run_round(3'b011);
    end
    // a lone M1 read leaves M1 as last, so the next tie goes to M0
    run_round(3'b010);
    run_round(3'b011);
  endtask

  task automatic test_write();
    r_aw = 32'h8000_0200; r_wdata = 32'hDEAD_BEEF; r_wstrb = 4'hF;
    r_awd = 2; r_wd = 0;
    run_round(3'b100);
  endtask

  task automatic test_wr_over_rd();
    r_a0 = 32'h8000_0010; r_d0 = 32'hCAFE_0001;
    r_aw = 32'h8000_0300; r_wdata = 32'h0BAD_F00D; r_wstrb = 4'h3;
    r_awd = 0; r_wd = 1;
    run_round(3'b101);
  endtask

  task automatic test_reset_mid_rd();
    m0_araddr = 32'h8000_0080; m0_arvalid = 1'b1;
    clk_step(); #1;
    n_chk++;
    if (s_arvalid !== 1'b1 || s_araddr !== 32'h8000_0080) begin
      n_fail++;
      $display("FAIL mid_rd_start: s_arvalid=%b s_araddr=%h, required 1 80000080", s_arvalid, s_araddr);
    end
    s_arready = 1'b1;
    clk_step();
    s_arready = 1'b0;
    repeat (3) clk_step();
    #1;
    n_chk++;
    if (s_rready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_rd_wait: s_rready=%b, required 1", s_rready);
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if (any_out !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: any output=%b within 1ns of rst, required 0", any_out);
    end
    m0_arvalid = 1'b0;
    clk_step(); clk_step();
    rst = 1'b0;
    model_last = 1'b1;
    #1;
    n_chk++;
    if (any_out !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: any output=%b, required 0", any_out);
    end
    r_a0 = 32'h8000_0084; r_a1 = 32'h8000_0184;
    r_d0 = 32'h0000_00AA; r_d1 = 32'h0000_00BB;
    run_round(3'b011);
  endtask

  task automatic test_random();
    logic [2:0] mask;
    for (int r = 0; r < 40; r++) begin
      r_a0 = $urandom & 32'hFFFF_FFFC;
      r_a1 = $urandom & 32'hFFFF_FFFC;
      r_aw = $urandom & 32'hFFFF_FFFC;
      r_d0 = $urandom;
      r_d1 = $urandom;
      r_wdata = $urandom;
      r_wstrb = 4'($urandom_range(0, 15));
      r_awd = $urandom_range(0, 3);
      r_wd = $urandom_range(0, 3);
      mask = 3'($urandom_range(1, 7));
      run_round(mask);
      repeat ($urandom_range(0, 2)) clk_step();
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_m0_alone();
    test_rr_pair();
    test_write();
    test_wr_over_rd();
    test_reset_mid_rd();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
